// File: rtl/ew_join_vec4.sv
// ---------------------------------------------------------------------------
// ew_join_vec4
//
// Joins a lambda token stream (Q0.16 unsigned lanes) with a u token stream
// (Q8.8 signed lanes) into one paired token for the EMA update stage. Each
// input has its own small FIFO. Tokens pair strictly in arrival order, and a
// state-address counter tags every joined token with its index in the
// current sequence. The payload passes through bit-exact.
//
// Configuration macro: EW_JOIN_OUT_REG_EN
//   undefined : the outputs are combinational from the FIFO heads and the
//               counter (push-to-out_valid latency 1 cycle)
//   defined   : the outputs come from a register slice that can reload in
//               the same cycle it drains (latency 2 cycles, full throughput)
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   lam_valid/lam_ready    lambda input handshake, lam_in payload
//   u_valid/u_ready        u input handshake, u_in payload
//   seq_clear              synchronous pulse that restarts the address count
//   seq_len                sequence length, 0 means 2^S_ADDR_W
//   out_valid/out_ready    joined-token handshake
//   lam_vec, u_vec         joined payload
//   s_addr, last           state index of the token, final-index flag
// ---------------------------------------------------------------------------

module EwJoinFifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_nonempty,
    output logic [DW-1:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on occupancy. A pop in the same cycle does not free a
    // slot for the incoming token, which keeps ready off the output path.
    assign o_ready    = (r_count != CNT_W'(DEPTH));
    assign o_nonempty = (r_count != '0);
    assign w_push     = i_valid && o_ready;
    assign w_pop      = i_pop && o_nonempty;
    assign o_head     = r_mem[r_rd];

    // The pointers wrap naturally because DEPTH is a power of two. The separate
    // occupancy count keeps full and empty distinct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset. Stale entries are never observable because the
    // head is only used while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

module ew_join_vec4 #(
    parameter int TILE_SIZE  = 4,
    parameter int W          = 16,
    parameter int S_ADDR_W   = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lam_valid,
    output logic                          lam_ready,
    input  logic [TILE_SIZE*W-1:0]        lam_in,
    input  logic                          u_valid,
    output logic                          u_ready,
    input  logic signed [TILE_SIZE*W-1:0] u_in,
    input  logic                          seq_clear,
    input  logic [S_ADDR_W-1:0]           seq_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TILE_SIZE*W-1:0]        lam_vec,
    output logic signed [TILE_SIZE*W-1:0] u_vec,
    output logic [S_ADDR_W-1:0]           s_addr,
    output logic                          last
);
    localparam int DW = TILE_SIZE * W;

    logic          w_lam_nonempty;
    logic          w_u_nonempty;
    logic [DW-1:0] w_lam_head;
    logic [DW-1:0] w_u_head;
    logic          w_join_valid;
    logic          w_pop;
    logic [S_ADDR_W-1:0] w_len_m1;
    logic [S_ADDR_W-1:0] r_cnt;

    EwJoinFifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_lam_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (lam_valid),
        .o_ready    (lam_ready),
        .i_data     (lam_in),
        .i_pop      (w_pop),
        .o_nonempty (w_lam_nonempty),
        .o_head     (w_lam_head)
    );

    EwJoinFifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (u_valid),
        .o_ready    (u_ready),
        .i_data     (u_in),
        .i_pop      (w_pop),
        .o_nonempty (w_u_nonempty),
        .o_head     (w_u_head)
    );

    assign w_join_valid = w_lam_nonempty && w_u_nonempty;

    // seq_len of 0 wraps to all-ones here, which is the 2^S_ADDR_W case.
    assign w_len_m1 = seq_len - S_ADDR_W'(1);

    // Address of the next token to leave the FIFOs. The counter wraps only on an
    // exact match with seq_len-1. If seq_len shrinks below the current count,
    // the counter runs on to its natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (seq_clear) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= (r_cnt == w_len_m1) ? '0 : r_cnt + S_ADDR_W'(1);
        end
    end

`ifdef EW_JOIN_OUT_REG_EN
    logic                r_out_valid;
    logic [DW-1:0]       r_lam;
    logic [DW-1:0]       r_u;
    logic [S_ADDR_W-1:0] r_addr;
    logic                r_last;

    // The slice loads whenever it is empty or is being drained this cycle. This
    // keeps one token per cycle under sustained streaming.
    assign w_pop = w_join_valid && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_lam       <= '0;
            r_u         <= '0;
            r_addr      <= '0;
            r_last      <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            r_out_valid <= w_join_valid;
            if (w_join_valid) begin
                r_lam  <= w_lam_head;
                r_u    <= w_u_head;
                r_addr <= r_cnt;
                r_last <= (r_cnt == w_len_m1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign lam_vec   = r_lam;
    assign u_vec     = r_u;
    assign s_addr    = r_addr;
    assign last      = r_last;
`else
    assign w_pop = w_join_valid && out_ready;

    // The payload and last are masked while no token is presented, so nothing
    // stale leaks out of the unreset FIFO storage during or after reset.
    assign out_valid = w_join_valid;
    assign lam_vec   = w_join_valid ? w_lam_head : '0;
    assign u_vec     = w_join_valid ? w_u_head : '0;
    assign s_addr    = r_cnt;
    assign last      = w_join_valid && (r_cnt == w_len_m1);
`endif
endmodule

// File: tb/tb_ew_join_vec4.sv
// ---------------------------------------------------------------------------
// tb_ew_join_vec4
//
// Self-checking bench for ew_join_vec4 in its default build. Each driver
// process streams tokens. A monitor keeps a token-level reference model: one
// queue per input holds the tokens buffered in the DUT. The monitor compares
// the handshake signals, payload, address and last against that model every
// cycle.
// ---------------------------------------------------------------------------

module tb_ew_join_vec4;
    localparam int TILE_SIZE  = 4;
    localparam int W          = 16;
    localparam int S_ADDR_W   = 10;
    localparam int FIFO_DEPTH = 2;
    localparam int DW         = TILE_SIZE * W;

    logic                 clk;
    logic                 rst_n;
    logic                 lam_valid;
    logic                 lam_ready;
    logic [DW-1:0]        lam_in;
    logic                 u_valid;
    logic                 u_ready;
    logic signed [DW-1:0] u_in;
    logic                 seq_clear;
    logic [S_ADDR_W-1:0]  seq_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        lam_vec;
    logic signed [DW-1:0] u_vec;
    logic [S_ADDR_W-1:0]  s_addr;
    logic                 last;

    ew_join_vec4 #(
        .TILE_SIZE  (TILE_SIZE),
        .W          (W),
        .S_ADDR_W   (S_ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lam_valid (lam_valid),
        .lam_ready (lam_ready),
        .lam_in    (lam_in),
        .u_valid   (u_valid),
        .u_ready   (u_ready),
        .u_in      (u_in),
        .seq_clear (seq_clear),
        .seq_len   (seq_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lam_vec   (lam_vec),
        .u_vec     (u_vec),
        .s_addr    (s_addr),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the tokens buffered in each FIFO, and the index the
    // next joined token must carry.
    logic [DW-1:0] lamQ [$];
    logic [DW-1:0] uQ [$];
    int expAddr = 0;

    int lamToSend = 0;
    int uToSend   = 0;
    int lamPct    = 100;
    int uPct      = 100;
    int readyPct  = 100;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int nLam, input int nU, input int lp, input int up, input int rp);
        lamPct    = lp;
        uPct      = up;
        readyPct  = rp;
        lamToSend = nLam;
        uToSend   = nU;
    endtask

    task automatic applyReset();
        @(posedge clk); #2;
        lamToSend = 0;
        uToSend   = 0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic bit drained();
        return lamToSend == 0 && uToSend == 0 && !lam_valid && !u_valid &&
               lamQ.size() == 0 && uQ.size() == 0;
    endfunction

    task automatic waitDrain(input int limit, input string name);
        int n = 0;
        while (!drained() && n < limit) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (!drained()) begin
            mismatched++;
            $display("[TB] FAIL %s actual=not drained after %0d cycles required=drained", name, limit);
        end
    endtask

    // The lambda driver holds each token stable until the DUT accepts it.
    initial begin : lamDriver
        bit fire;
        lam_valid = 1'b0;
        lam_in    = '0;
        forever begin
            @(negedge clk);
            fire = lam_valid && lam_ready && rst_n;
            @(posedge clk); #1;
            if (!rst_n) begin
                lam_valid = 1'b0;
            end else if (fire || !lam_valid) begin
                if (lamToSend > 0 && $urandom_range(99) < lamPct) begin
                    lam_valid = 1'b1;
                    lam_in    = DW'({$urandom, $urandom});
                    lamToSend--;
                end else begin
                    lam_valid = 1'b0;
                end
            end
        end
    end

    initial begin : uDriver
        bit fire;
        u_valid = 1'b0;
        u_in    = '0;
        forever begin
            @(negedge clk);
            fire = u_valid && u_ready && rst_n;
            @(posedge clk); #1;
            if (!rst_n) begin
                u_valid = 1'b0;
            end else if (fire || !u_valid) begin
                if (uToSend > 0 && $urandom_range(99) < uPct) begin
                    u_valid = 1'b1;
                    u_in    = DW'({$urandom, $urandom});
                    uToSend--;
                end else begin
                    u_valid = 1'b0;
                end
            end
        end
    end

    initial begin : readyDriver
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) < readyPct);
        end
    end

    // The monitor samples mid-cycle. All inputs and outputs are settled then,
    // and any handshake it sees completes at the next rising edge.
    always @(negedge clk) begin : monitor
        bit expValid;
        int modLen;
        if (!rst_n) begin
            lamQ.delete();
            uQ.delete();
            expAddr = 0;
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_s_addr", s_addr, 0);
            checkOutput("rst_last", last, 0);
            checkOutput("rst_lam_vec", lam_vec, 0);
            checkOutput("rst_u_vec", $unsigned(u_vec), 0);
        end else begin
            expValid = lamQ.size() > 0 && uQ.size() > 0;
            modLen   = (seq_len == 0) ? (1 << S_ADDR_W) : int'(seq_len);
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("lam_ready", lam_ready, lamQ.size() < FIFO_DEPTH);
            checkOutput("u_ready", u_ready, uQ.size() < FIFO_DEPTH);
            if (expValid) begin
                checkOutput("lam_vec", lam_vec, lamQ[0]);
                checkOutput("u_vec", $unsigned(u_vec), uQ[0]);
                checkOutput("s_addr", s_addr, expAddr);
                checkOutput("last", last, expAddr == modLen - 1);
            end
            if (expValid && out_ready) begin
                void'(lamQ.pop_front());
                void'(uQ.pop_front());
                if (expAddr < modLen) expAddr = (expAddr + 1) % modLen;
                else                  expAddr = (expAddr + 1) % (1 << S_ADDR_W);
            end
            if (seq_clear) expAddr = 0;
            if (lam_valid && lam_ready) lamQ.push_back(lam_in);
            if (u_valid && u_ready) uQ.push_back(u_in);
        end
    end

    initial begin : mainSeq
        bit found;
        int n;
        rst_n     = 1'b0;
        seq_clear = 1'b0;
        seq_len   = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_lam_ready", lam_ready, 1);
        checkOutput("post_rst_u_ready", u_ready, 1);

        // A single token on each stream appears one cycle after its push.
        applyStimulus(1, 1, 100, 100, 100);
        n = 0;
        while (!(lam_valid && u_valid) && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("latency_1cycle", out_valid, 1);
        waitDrain(20, "single_drain");

        // Three lambda tokens arrive before any u token. Lambda stalls after two.
        applyReset();
        applyStimulus(3, 0, 100, 0, 100);
        repeat (6) @(negedge clk);
        checkOutput("imbalance_lam_ready", lam_ready, 0);
        checkOutput("imbalance_lam_valid", lam_valid, 1);
        uPct    = 100;
        uToSend = 3;
        waitDrain(40, "imbalance_drain");

        // seq_len=3 with seven back-to-back tokens at one token per cycle.
        applyReset();
        seq_len = 10'd3;
        applyStimulus(7, 7, 100, 100, 100);
        waitDrain(15, "throughput_drain");

        // Output stalled while both FIFOs are full.
        applyReset();
        seq_len = '0;
        applyStimulus(4, 4, 100, 100, 0);
        repeat (8) @(negedge clk);
        checkOutput("stall_lam_ready", lam_ready, 0);
        checkOutput("stall_u_ready", u_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        readyPct = 100;
        waitDrain(40, "stall_drain");

        // seq_clear coincides with the pop at s_addr=5.
        applyReset();
        seq_len = '0;
        applyStimulus(12, 12, 100, 100, 100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (out_valid && out_ready && s_addr == 10'd5) begin
                found     = 1'b1;
                seq_clear = 1'b1;
                @(posedge clk); #2;
                seq_clear = 1'b0;
                checkOutput("clear_s_addr", s_addr, 0);
            end
        end
        checkOutput("clear_reached_addr5", found, 1);
        waitDrain(40, "clear_drain");

        // Reset asserted with both FIFOs full.
        applyReset();
        applyStimulus(4, 4, 100, 100, 0);
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        lamToSend = 0;
        uToSend   = 0;
        rst_n     = 1'b0;
        #1 checkOutput("midrst_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        readyPct = 100;
        @(negedge clk);
        checkOutput("midrst_lam_ready", lam_ready, 1);
        checkOutput("midrst_u_ready", u_ready, 1);
        checkOutput("midrst_s_addr", s_addr, 0);

        // Random traffic with changing seq_len and occasional seq_clear pulses.
        for (int blk = 0; blk < 8; blk++) begin
            seq_len = S_ADDR_W'($urandom_range(0, 8));
            applyStimulus(40, 40, $urandom_range(30, 100), $urandom_range(30, 100),
                          $urandom_range(30, 100));
            n = 0;
            while (!drained() && n < 1000) begin
                @(posedge clk); #2;
                seq_clear = ($urandom_range(99) < 3);
                if ($urandom_range(99) < 2) seq_len = S_ADDR_W'($urandom_range(0, 6));
                n++;
            end
            seq_clear = 1'b0;
            waitDrain(50, "random_drain");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ew_join_vec4.md
EW_JOIN_VEC4 -- requirements
Module: ew_join_vec4

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 4, lanes per token.
REQ-002 SHALL have parameter W, default 16, bits per lane.
REQ-003 SHALL have parameter S_ADDR_W, default 10, state address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, entries per input FIFO, a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports lam_valid (input, 1), lam_ready (output, 1) and lam_in (input, TILE_SIZE x W), forming the lambda stream, Q0.16 unsigned.
REQ-008 SHALL have ports u_valid (input, 1), u_ready (output, 1) and u_in (input, TILE_SIZE x W signed), forming the u stream, Q8.8 signed.
REQ-009 SHALL have port seq_clear, input, 1, a synchronous pulse that restarts the address sequence.
REQ-010 SHALL have port seq_len, input, S_ADDR_W, sequence length; 0 means 2^S_ADDR_W.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the joined-token handshake to the EMA update stage.
REQ-012 SHALL have ports lam_vec (output, TILE_SIZE x W) and u_vec (output, TILE_SIZE x W signed), the joined payload.
REQ-013 SHALL have port s_addr, output, S_ADDR_W, state index of the presented token.
REQ-014 SHALL have port last, output, 1, high when s_addr is the final index of the sequence.

Function
REQ-015 Each input SHALL feed its own FIFO of FIFO_DEPTH entries.
- ready = !full, independent of a pop in the same cycle (no pass-through when full).
- Push occurs on valid && ready.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked so that full and empty are unambiguous.
REQ-017 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-018 A pushed token SHALL become visible at the FIFO head on the next cycle.
REQ-019 The joined token SHALL be valid only when both FIFOs are non-empty.
REQ-020 A pop SHALL occur on out_valid && out_ready and SHALL dequeue exactly one entry from each FIFO.
REQ-021 Lambda and u tokens SHALL pair strictly in arrival order, with no reordering or dropping. Imbalanced arrival SHALL stall the leading stream via its ready signal.
REQ-022 While out_valid && !out_ready, lam_vec, u_vec, s_addr and last SHALL hold stable.
REQ-023 An address counter SHALL drive s_addr.
- Increments by 1 per pop.
- Wraps to 0 after index seq_len-1; with seq_len=0 it wraps at 2^S_ADDR_W-1.
REQ-024 last SHALL equal (s_addr == seq_len-1), evaluated modulo 2^S_ADDR_W.
REQ-025 seq_clear SHALL set the counter to 0 on the next edge.
- Takes priority over a same-cycle increment.
- Does not flush the FIFOs.
REQ-026 A change of seq_len mid-sequence SHALL take effect at the next comparison. If the counter is already beyond the new seq_len-1, it SHALL continue to the natural wrap.
REQ-027 The payload SHALL be passed through bit-exact; no arithmetic is performed.
REQ-028 Sustained throughput SHALL be one token per cycle when both inputs stream and out_ready=1.

Reset
REQ-029 While rst_n=0:
- FIFOs empty, counter=0.
- out_valid=0, last=0, s_addr=0, lam_vec=0, u_vec=0.
REQ-030 After reset, lam_ready and u_ready SHALL be 1 on the first cycle after deassertion.
REQ-031 Reset asserted mid-stream SHALL discard all buffered tokens immediately.

Configuration
REQ-032 Macro EW_JOIN_OUT_REG_EN SHALL control the output stage.
- Defined: lam_vec, u_vec, s_addr, last and out_valid come from a register slice that reloads in the same cycle it drains, preserving full throughput. Latency from input push to out_valid is 2 cycles.
- Undefined: outputs are combinational from the FIFO heads and counter. Latency is 1 cycle.

Verification
REQ-033 Both streams push one token at cycle 0 with out_ready=1 -> out_valid at cycle 1 (cycle 2 with macro), s_addr=0, payload bit-exact.
REQ-034 3 lambda tokens arrive before any u token, FIFO_DEPTH=2 -> lam_ready=0 after 2 pushes; the later u tokens pair in order with s_addr 0,1,2.
REQ-035 seq_len=3 with 7 continuous tokens -> s_addr 0,1,2,0,1,2,0 and last high on each index 2.
REQ-036 out_ready=0 for 5 cycles with both FIFOs full -> outputs stable, both readies 0, no loss; 4 tokens drain after release.
REQ-037 seq_clear on the same cycle as a pop at s_addr=5 -> next s_addr=0 and the FIFO contents are preserved.
REQ-038 rst_n asserted with both FIFOs full -> out_valid=0 immediately, both readies 1 after release, s_addr=0.
